// File: rtl/mtp_pkg.sv
// Shared mode encodings and status-state type for the mtp combiner family.
package mtp_pkg;

  localparam logic [1:0] MTP_XOR  = 2'b00;
  localparam logic [1:0] MTP_AND  = 2'b01;
  localparam logic [1:0] MTP_OR   = 2'b10;
  localparam logic [1:0] MTP_XNOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } mtp_state_e;

endpackage

// File: rtl/mtp_term.sv
// Combinational per-bit term of two operands, selected by a 2-bit mode.
module mtp_term
  import mtp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   mode,
  output logic [W-1:0] t
);

  logic [W-1:0] p;
  logic [W-1:0] q;

  assign p = x | y;
  assign q = x & y;

  always_comb begin
    t = p ^ q;
    case (mode)
      MTP_XOR:  t = p ^ q;
      MTP_AND:  t = q;
      MTP_OR:   t = p;
      MTP_XNOR: t = ~(p ^ q);
      default:  t = p ^ q;
    endcase
  end

endmodule

// File: rtl/mtp_accum.sv
// Frame accumulator: XOR-folds LEN per-beat terms and presents the result
// on a valid/ready output, counting completed frames.
module mtp_accum
  import mtp_pkg::*;
#(
  parameter int W   = 8,
  parameter int LEN = 4,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  input  logic [W-1:0]  in_y,
  input  logic [1:0]    mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_z,
  output logic [CW-1:0] frame_cnt
);

  localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(LEN - 1);

  logic [W-1:0]  acc, acc_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [1:0]    mode_r, mode_nx;
  logic [W-1:0]  out_z_nx;
  logic          out_valid_nx;
  logic [CW-1:0] frame_cnt_nx;

  logic          accept;
  logic          first;
  logic [1:0]    mode_sel;
  logic [W-1:0]  t;
  logic [W-1:0]  fold;
  mtp_state_e    state;

  assign first    = (beat == '0);
  assign mode_sel = first ? mode : mode_r;
  assign accept   = in_valid && in_ready;
  // A frame always restarts from zero, so the first beat ignores acc.
  assign fold     = (first ? '0 : acc) ^ t;

  mtp_term #(.W(W)) u_term (
    .x    (in_x),
    .y    (in_y),
    .mode (mode_sel),
    .t    (t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      beat      <= '0;
      mode_r    <= MTP_XOR;
      out_z     <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      acc       <= acc_nx;
      beat      <= beat_nx;
      mode_r    <= mode_nx;
      out_z     <= out_z_nx;
      out_valid <= out_valid_nx;
      frame_cnt <= frame_cnt_nx;
    end
  end

  always_comb begin
    acc_nx       = acc;
    beat_nx      = beat;
    mode_nx      = mode_r;
    out_z_nx     = out_z;
    out_valid_nx = out_valid;
    frame_cnt_nx = frame_cnt;
    if (out_valid && out_ready) begin
      out_valid_nx = 1'b0;
    end
    if (accept) begin
      if (first) begin
        mode_nx = mode;
      end
      if (beat == LAST) begin
        // Completion overrides a same-cycle consume so the new result stays valid.
        out_z_nx     = fold;
        out_valid_nx = 1'b1;
        acc_nx       = '0;
        beat_nx      = '0;
        frame_cnt_nx = frame_cnt + 1'b1;
      end else begin
        acc_nx  = fold;
        beat_nx = beat + 1'b1;
      end
    end
  end

  always_comb begin
    if (out_valid)   state = ST_HOLD;
    else if (!first) state = ST_ACC;
    else             state = ST_IDLE;
    in_ready = (state != ST_HOLD) || out_ready;
  end

endmodule

// File: tb/tb_mtp_accum.sv
// Scoreboard bench for mtp_accum (LEN=4 instance plus a LEN=1 instance).
module tb_mtp_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_x, in_y, out_z, frame_cnt;
  logic [1:0] mode;

  logic       iv1, ir1, ov1, or1;
  logic [7:0] x1, y1, z1, fc1;
  logic [1:0] md1;

  int nchecks = 0;
  int nerr    = 0;

  // model state for the LEN=4 instance
  int         m_beat;
  logic [1:0] m_mode;
  logic [7:0] m_acc;
  logic [7:0] m_fcnt;
  logic [15:0] sbq[$];
  logic       prev_stall;
  logic [7:0] prev_z;

  always #5 clk = ~clk;

  mtp_accum #(.W(8), .LEN(4), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .frame_cnt(frame_cnt)
  );

  mtp_accum #(.W(8), .LEN(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
    .in_x(x1), .in_y(y1), .mode(md1), .out_valid(ov1),
    .out_ready(or1), .out_z(z1), .frame_cnt(fc1)
  );

  // reference term built bit by bit from a truth table
  function automatic logic [7:0] ref_term(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'b00: r[i] = (a[i] != b[i]);
        2'b01: r[i] = (a[i] == 1'b1) && (b[i] == 1'b1);
        2'b10: r[i] = (a[i] == 1'b1) || (b[i] == 1'b1);
        default: r[i] = (a[i] == b[i]);
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    m_beat = 0; m_mode = 2'b00; m_acc = 8'h00; m_fcnt = 8'h00;
    sbq.delete();
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_x = '0; in_y = '0; mode = '0;
    iv1 = 1'b0; or1 = 1'b0; x1 = '0; y1 = '0; md1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // one clock of stimulus on the LEN=4 instance with scoreboard checking
  task automatic step(input logic iv, input logic [7:0] x, input logic [7:0] y,
                      input logic [1:0] md, input logic ordy);
    logic acc_ok, hs;
    logic [15:0] e;
    logic [7:0] t;
    in_valid = iv; in_x = x; in_y = y; mode = md; out_ready = ordy;
    @(negedge clk);
    nchecks++;
    if (out_valid !== (sbq.size() != 0)) begin
      nerr++;
      $display("FAIL out_valid_seq: got %b expected %b", out_valid, (sbq.size() != 0));
    end
    nchecks++;
    if (in_ready !== (!out_valid || ordy)) begin
      nerr++;
      $display("FAIL in_ready: got %b expected %b", in_ready, (!out_valid || ordy));
    end
    if (prev_stall) begin
      nchecks++;
      if (out_valid !== 1'b1 || out_z !== prev_z) begin
        nerr++;
        $display("FAIL hold_stable: valid %b z %h expected 1 %h", out_valid, out_z, prev_z);
      end
    end
    acc_ok = iv && in_ready;
    hs = out_valid && ordy;
    prev_stall = out_valid && !ordy;
    prev_z = out_z;
    if (hs && sbq.size() != 0) begin
      e = sbq.pop_front();
      nchecks++;
      if (out_z !== e[7:0] || frame_cnt !== e[15:8]) begin
        nerr++;
        $display("FAIL result: z %h cnt %0d expected z %h cnt %0d",
                 out_z, frame_cnt, e[7:0], e[15:8]);
      end
    end
    @(posedge clk); #1;
    if (acc_ok) begin
      if (m_beat == 0) begin
        m_mode = md;
        m_acc = 8'h00;
      end
      t = ref_term(x, y, m_mode);
      m_acc = m_acc ^ t;
      if (m_beat == 3) begin
        m_fcnt = m_fcnt + 8'd1;
        sbq.push_back({m_fcnt, m_acc});
        m_beat = 0;
        m_acc = 8'h00;
      end else begin
        m_beat++;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    nchecks++;
    if (out_valid !== 1'b0 || out_z !== 8'h00 || frame_cnt !== 8'h00 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_state: v %b z %h cnt %0d rdy %b expected 0 00 0 1",
               out_valid, out_z, frame_cnt, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_xor_frame();
    step(1, 8'h0F, 8'h00, 2'b00, 1);
    step(1, 8'hF0, 8'h00, 2'b00, 1);
    step(1, 8'h01, 8'h01, 2'b00, 1);
    step(1, 8'h80, 8'h00, 2'b00, 1);
    nchecks++;
    if (out_valid !== 1'b1 || out_z !== 8'h7F || frame_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL xor_frame: v %b z %h cnt %0d expected 1 7f 1", out_valid, out_z, frame_cnt);
    end
    step(0, 8'h00, 8'h00, 2'b00, 1);
  endtask

  task automatic test_mode_latch();
    step(1, 8'hFF, 8'hFF, 2'b01, 1);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 8'hFF, 2'b10, 1);
    nchecks++;
    if (out_valid !== 1'b1 || out_z !== 8'h00) begin
      nerr++;
      $display("FAIL mode_latch: v %b z %h expected 1 00", out_valid, out_z);
    end
    step(0, 8'h00, 8'h00, 2'b00, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) step(1, 8'(i * 3 + 1), 8'h22, 2'b00, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h11, 8'h05, 2'b10, 0);
      nchecks++;
      if (in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_stall: in_ready %b expected 0", in_ready);
      end
    end
    step(1, 8'h11, 8'h05, 2'b10, 1);
    for (int i = 0; i < 3; i++) step(1, 8'h30, 8'h03, 2'b00, 1);
    step(0, 8'h00, 8'h00, 2'b00, 1);
  endtask

  task automatic test_len1_wrap();
    logic [7:0] ec;
    ec = 8'd0;
    iv1 = 1'b1; x1 = 8'hAA; y1 = 8'h55; md1 = 2'b11; or1 = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      if (ir1 !== 1'b1) begin
        nchecks++; nerr++;
        $display("FAIL len1_ready: got %b expected 1", ir1);
      end
      @(posedge clk); #1;
      ec = ec + 8'd1;
      nchecks++;
      if (ov1 !== 1'b1 || z1 !== 8'h00 || fc1 !== ec) begin
        nerr++;
        $display("FAIL len1_stream: v %b z %h cnt %0d expected 1 00 %0d", ov1, z1, fc1, ec);
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_reset_midframe();
    step(1, 8'h01, 8'h00, 2'b10, 1);
    step(1, 8'h01, 8'h00, 2'b10, 1);
    do_reset();
    @(negedge clk);
    nchecks++;
    if (out_valid !== 1'b0 || out_z !== 8'h00 || frame_cnt !== 8'h00 || in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL midframe_reset: v %b z %h cnt %0d rdy %b expected 0 00 0 1",
               out_valid, out_z, frame_cnt, in_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1, 8'h01, 8'h00, 2'b10, 1);
    nchecks++;
    if (out_valid !== 1'b1 || out_z !== 8'h00 || frame_cnt !== 8'd1) begin
      nerr++;
      $display("FAIL after_reset_frame: v %b z %h cnt %0d expected 1 00 1", out_valid, out_z, frame_cnt);
    end
    step(0, 8'h00, 8'h00, 2'b00, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           2'($urandom), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 8'h00, 2'b00, 1);
    nchecks++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL random_drain: %0d results outstanding expected 0", sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_xor_frame();
    test_mode_latch();
    test_backpressure();
    test_len1_wrap();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
